// File: rtl/sa_cache_ctrl.sv
// Set-associative write-back cache tag/state controller with saturating statistics.
// Three-cycle request flow: IDLE accepts, LOOKUP compares tags and picks a victim, UPDATE commits.
module sa_cache_ctrl #(
    parameter int NUM_SETS    = 32,
    parameter int NUM_WAYS    = 8,
    parameter int LINE_SIZE   = 64,
    parameter int ADDR_W      = 32,
    parameter int REPL_POLICY = 0,
    parameter int CNT_W       = 32,
    localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic              rsp_evict,
    output logic              rsp_writeback,
    output logic [WAY_W-1:0]  rsp_way,
    output logic              rsp_illegal,
    input  logic              stats_clear,
    output logic [CNT_W-1:0]  cnt_access,
    output logic [CNT_W-1:0]  cnt_read,
    output logic [CNT_W-1:0]  cnt_write,
    output logic [CNT_W-1:0]  cnt_inval,
    output logic [CNT_W-1:0]  cnt_hit,
    output logic [CNT_W-1:0]  cnt_miss,
    output logic [CNT_W-1:0]  cnt_evict,
    output logic [CNT_W-1:0]  cnt_wb
);
    localparam int OFF_W = $clog2(LINE_SIZE);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(NUM_WAYS - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_INVAL, OP_RSVD} op_t;

    state_t state_q, state_d;
    op_t    op_q;
    logic [TAG_W-1:0] tag_r;
    logic [IDX_W-1:0] idx_r;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [NUM_WAYS-1:0] mru_q   [NUM_SETS];
    logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];

    logic             hit_c, inv_found, plru_found;
    logic [WAY_W-1:0] hit_way_c, inv_way, lru_way, plru_way, victim;
    logic             hit_r, evict_r, wb_r, illegal_r;
    logic [WAY_W-1:0] way_r;
    logic [NUM_WAYS-1:0] mru_next;
    logic             fill_op;
    logic             unused_offset;

    assign unused_offset = ^req_addr[OFF_W-1:0];
    assign fill_op = (op_q == OP_READ) || (op_q == OP_WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) state_d = LOOKUP;
            end
            LOOKUP:  state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // First match wins for hit and invalid-way search, giving lowest-index priority.
    always_comb begin
        hit_c      = 1'b0;
        hit_way_c  = '0;
        inv_found  = 1'b0;
        inv_way    = '0;
        lru_way    = '0;
        plru_found = 1'b0;
        plru_way   = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!hit_c && valid_q[idx_r][w] && tag_q[idx_r][w] == tag_r) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!inv_found && !valid_q[idx_r][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_q[idx_r][w] == AGE_MAX) lru_way = WAY_W'(w);
            if (!plru_found && !mru_q[idx_r][w]) begin
                plru_found = 1'b1;
                plru_way   = WAY_W'(w);
            end
        end
        if (inv_found)             victim = inv_way;
        else if (REPL_POLICY == 0) victim = lru_way;
        else                       victim = plru_way;
    end

    always_comb begin
        mru_next = mru_q[idx_r] | (NUM_WAYS'(1) << way_r);
        if (&mru_next) mru_next = NUM_WAYS'(1) << way_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_READ;
            tag_r     <= '0;
            idx_r     <= '0;
            hit_r     <= 1'b0;
            evict_r   <= 1'b0;
            wb_r      <= 1'b0;
            illegal_r <= 1'b0;
            way_r     <= '0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                op_q  <= op_t'(req_type);
                tag_r <= req_addr[ADDR_W-1:IDX_W+OFF_W];
                idx_r <= req_addr[IDX_W+OFF_W-1:OFF_W];
            end
            if (state_q == LOOKUP) begin
                illegal_r <= (op_q == OP_RSVD);
                hit_r     <= (op_q != OP_RSVD) && hit_c;
                if (op_q == OP_RSVD)      way_r <= '0;
                else if (hit_c)           way_r <= hit_way_c;
                else if (op_q == OP_INVAL) way_r <= '0;
                else                      way_r <= victim;
                evict_r <= fill_op && !hit_c && valid_q[idx_r][victim];
                wb_r    <= fill_op && !hit_c && valid_q[idx_r][victim] && dirty_q[idx_r][victim];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                mru_q[s]   <= '0;
                for (int unsigned w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
            end
        end else if (state_q == UPDATE) begin
            unique case (op_q)
                OP_READ, OP_WRITE: begin
                    valid_q[idx_r][way_r] <= 1'b1;
                    if (op_q == OP_WRITE) dirty_q[idx_r][way_r] <= 1'b1;
                    else if (!hit_r)      dirty_q[idx_r][way_r] <= 1'b0;
                    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                        if (age_q[idx_r][w] < age_q[idx_r][way_r])
                            age_q[idx_r][w] <= age_q[idx_r][w] + 1'b1;
                    end
                    age_q[idx_r][way_r] <= '0;
                    mru_q[idx_r] <= mru_next;
                end
                OP_INVAL: begin
                    if (hit_r) begin
                        valid_q[idx_r][way_r] <= 1'b0;
                        dirty_q[idx_r][way_r] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tags are qualified by valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (state_q == UPDATE && fill_op && !hit_r) tag_q[idx_r][way_r] <= tag_r;
    end

    assign rsp_valid     = (state_q == UPDATE);
    assign rsp_hit       = rsp_valid && hit_r;
    assign rsp_evict     = rsp_valid && evict_r;
    assign rsp_writeback = rsp_valid && wb_r;
    assign rsp_illegal   = rsp_valid && illegal_r;
    assign rsp_way       = rsp_valid ? way_r : '0;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic en);
        return (en && c != '1) ? c + 1'b1 : c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst || stats_clear) begin
            cnt_access <= '0;
            cnt_read   <= '0;
            cnt_write  <= '0;
            cnt_inval  <= '0;
            cnt_hit    <= '0;
            cnt_miss   <= '0;
            cnt_evict  <= '0;
            cnt_wb     <= '0;
        end else if (state_q == UPDATE) begin
            cnt_access <= bump(cnt_access, 1'b1);
            cnt_read   <= bump(cnt_read,   op_q == OP_READ);
            cnt_write  <= bump(cnt_write,  op_q == OP_WRITE);
            cnt_inval  <= bump(cnt_inval,  op_q == OP_INVAL);
            cnt_hit    <= bump(cnt_hit,    fill_op && hit_r);
            cnt_miss   <= bump(cnt_miss,   fill_op && !hit_r);
            cnt_evict  <= bump(cnt_evict,  evict_r);
            cnt_wb     <= bump(cnt_wb,     wb_r);
        end
    end

endmodule
